uart_tx_buf: RTL



---
 rtl/uart_tx_buf_pkg.sv | 18 +
 rtl/uart_tx_buf_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx_buf.sv | 127 ++++++++++++
 4 files changed

// File: rtl/uart_tx_buf_pkg.sv
// Shared UART transmit constants, state codes and bus types.
package uart_tx_buf_pkg;

    localparam int UART_DIV_RATE = 16;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef logic [7:0] byte_data_t;
    typedef logic [2:0] uart_bit_cnt_t;
    typedef logic [1:0] uart_tx_state_t;

    localparam uart_tx_state_t UART_TX_STATE_IDLE  = 2'd0;
    localparam uart_tx_state_t UART_TX_STATE_START = 2'd1;
    localparam uart_tx_state_t UART_TX_STATE_DATA  = 2'd2;
    localparam uart_tx_state_t UART_TX_STATE_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_buf_if.sv
// Byte push handshake between the bus-side controller and the UART transmitter.
interface uart_tx_buf_if;
    import uart_tx_buf_pkg::*;

    logic       tx_valid;
    byte_data_t tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO; read data is shown ahead from the head entry.
module uart_tx_fifo
    import uart_tx_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  byte_data_t wr_data,
    input  logic       rd_en,
    output byte_data_t rd_data,
    output logic [AW:0] level,
    output logic       full,
    output logic       empty
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    byte_data_t    mem_q [DEPTH];
    logic          do_wr, do_rd;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_wr, do_rd})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: FIFO front end, bit FSM, divider, shifter.
module uart_tx_buf
    import uart_tx_buf_pkg::*;
#(
    parameter int DIV_RATE   = UART_DIV_RATE,
    parameter int FIFO_DEPTH = 4,
    localparam int LW = $clog2(FIFO_DEPTH) + 1,
    localparam int DW = $clog2(DIV_RATE)
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_buf_if.slave  bus,
    output logic          tx_busy,
    output logic          tx_end,
    output logic [LW-1:0] fifo_level,
    output logic          tx
);

    localparam logic [DW-1:0] DIV_MAX = DW'(DIV_RATE - 1);

    uart_tx_state_t state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    uart_bit_cnt_t  bit_q, bit_d;
    byte_data_t     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           tx_end_q, tx_end_d;
    logic           pop, push;
    logic           fifo_full, fifo_empty;
    byte_data_t     rd_data;

    assign bus.tx_ready = !fifo_full;
    assign push         = bus.tx_valid && !fifo_full;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (bus.tx_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // tx is derived from the current state, so the line lags the FSM by one edge.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = UART_STOP_BIT;
        tx_end_d = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            UART_TX_STATE_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = rd_data;
                    div_d   = DIV_MAX;
                    state_d = UART_TX_STATE_START;
                end
            end
            UART_TX_STATE_START: begin
                tx_d = UART_START_BIT;
                if (div_q == '0) begin
                    div_d   = DIV_MAX;
                    bit_d   = '0;
                    state_d = UART_TX_STATE_DATA;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            UART_TX_STATE_DATA: begin
                tx_d = shift_q[0];
                if (div_q == '0) begin
                    shift_d = shift_q >> 1;
                    div_d   = DIV_MAX;
                    if (bit_q == 3'd7) state_d = UART_TX_STATE_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            UART_TX_STATE_STOP: begin
                tx_d = UART_STOP_BIT;
                if (div_q == '0) begin
                    tx_end_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = rd_data;
                        div_d   = DIV_MAX;
                        state_d = UART_TX_STATE_START;
                    end else begin
                        state_d = UART_TX_STATE_IDLE;
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            default: state_d = UART_TX_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= UART_TX_STATE_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            tx_end_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            tx_end_q <= tx_end_d;
        end
    end

    assign tx      = tx_q;
    assign tx_end  = tx_end_q;
    assign tx_busy = (state_q != UART_TX_STATE_IDLE) || (fifo_level != '0);

endmodule
